// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage definitions: IMEM window, widths and the fetch-entry layout.
package cpu31_defs;

  localparam int XLEN        = 32;
  localparam int IMEM_AW     = 11;
  localparam int QUEUE_DEPTH = 2;

  localparam logic [XLEN-1:0] RESET_PC   = 32'h0040_0000;
  localparam logic [XLEN-1:0] IMEM_BYTES = 32'(4 * (2 ** IMEM_AW));
  localparam logic [XLEN-1:0] IMEM_END   = RESET_PC + IMEM_BYTES;

  // One queued fetch: the byte PC and the instruction word read from IMEM there.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // A PC is unfetchable when it is not word aligned or lies outside the IMEM window.
  function automatic logic pc_faults(input logic [XLEN-1:0] pc);
    return (pc[1:0] != 2'b00) || (pc < RESET_PC) || (pc >= IMEM_END);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Two-entry FIFO of fetch entries with flush and same-cycle push/pop.
module fetch_queue
  import cpu31_defs::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_entry_i,
  input  logic         pop_i,
  output logic         valid_o,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  fetch_entry_t mem_q [QUEUE_DEPTH];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         pop_ok;

  assign pop_ok = pop_i && (count_q != 2'd0);

  // Next pointer/count values; a flush empties the queue regardless of push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_i) wr_ptr_d = ~wr_ptr_q;
      if (pop_ok) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push_i} - {1'b0, pop_ok};
    end
  end

  // Pointer, count and storage registers; a push into the slot being popped is safe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < QUEUE_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, addresses IMEM, queues fetched words and handles redirects.
module instr_fetch_unit
  import cpu31_defs::*;
(
  input  logic               clk,
  input  logic               rst_n,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_instr,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_instr,
  output logic [XLEN-1:0]    out_pc,
  output logic [XLEN-1:0]    out_pc4,
  output logic               fetch_fault
);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            fault_q, fault_d;
  logic            pop, push;
  logic            q_valid;
  logic [1:0]      q_count;
  fetch_entry_t    head, push_entry;

  assign imem_addr  = IMEM_AW'((fetch_pc_q - RESET_PC) >> 2);
  assign pop        = q_valid && out_ready;
  assign push       = !redirect_valid && !fault_q && ((q_count < 2'(QUEUE_DEPTH)) || pop);
  assign push_entry = '{pc: fetch_pc_q, instr: imem_instr};

  // Next fetch PC: redirect wins, otherwise advance one word per push; fault tracks the new PC.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    fault_d = pc_faults(fetch_pc_d);
  end

  // Fetch PC and fault flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      fault_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      fault_q    <= fault_d;
    end
  end

  fetch_queue u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (redirect_valid),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop && !redirect_valid),
    .valid_o      (q_valid),
    .head_o       (head),
    .count_o      (q_count)
  );

  assign out_valid   = q_valid;
  assign out_instr   = q_valid ? head.instr : '0;
  assign out_pc      = q_valid ? head.pc : '0;
  assign out_pc4     = q_valid ? (head.pc + 32'd4) : '0;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: vector table plus hand-written stall, redirect and reset sequences.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;
  logic        fetch_fault;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        redir;
    logic [31:0] redirPc;
    logic        ready;
    logic        expValid;
    logic [31:0] expPc;
    logic        expFault;
    logic [10:0] expAddr;
  } vec_t;

  vec_t vecs [18];

  always #5 clk = ~clk;

  // IMEM model: word k holds 0x1000_0000 + k.
  assign imem_instr = 32'h1000_0000 + {21'd0, imem_addr};

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc4        (out_pc4),
    .fetch_fault    (fetch_fault)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkState(input string tag, input logic expValid, input logic [31:0] expPc,
                            input logic expFault, input logic [10:0] expAddr);
    logic [31:0] expInstr;
    logic [31:0] expPc4;
    expInstr = expValid ? (32'h1000_0000 + ((expPc - 32'h0040_0000) >> 2)) : 32'd0;
    expPc4   = expValid ? (expPc + 32'd4) : 32'd0;
    checkOutput({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, expValid});
    checkOutput({tag, " out_pc"}, out_pc, expValid ? expPc : 32'd0);
    checkOutput({tag, " out_pc4"}, out_pc4, expPc4);
    checkOutput({tag, " out_instr"}, out_instr, expInstr);
    checkOutput({tag, " fetch_fault"}, {31'd0, fetch_fault}, {31'd0, expFault});
    checkOutput({tag, " imem_addr"}, {21'd0, imem_addr}, {21'd0, expAddr});
  endtask

  task automatic applyStimulus(input logic redir, input logic [31:0] redirPc, input logic ready);
    redirect_valid = redir;
    redirect_pc    = redirPc;
    out_ready      = ready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two cycles and release it between clock edges.
  task automatic doReset(input logic readyAfter);
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0);
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'd0, readyAfter);
  endtask

  initial begin
    // redir, redirPc, ready, expValid, expPc, expFault, expAddr
    vecs[0]  = '{1'b0, 32'h0,          1'b1, 1'b1, 32'h0040_0000, 1'b0, 11'h001};
    vecs[1]  = '{1'b0, 32'h0,          1'b1, 1'b1, 32'h0040_0004, 1'b0, 11'h002};
    vecs[2]  = '{1'b0, 32'h0,          1'b1, 1'b1, 32'h0040_0008, 1'b0, 11'h003};
    vecs[3]  = '{1'b0, 32'h0,          1'b0, 1'b1, 32'h0040_0008, 1'b0, 11'h004};
    vecs[4]  = '{1'b0, 32'h0,          1'b0, 1'b1, 32'h0040_0008, 1'b0, 11'h004};
    vecs[5]  = '{1'b0, 32'h0,          1'b1, 1'b1, 32'h0040_000C, 1'b0, 11'h005};
    vecs[6]  = '{1'b1, 32'h0040_0100,  1'b1, 1'b0, 32'h0,         1'b0, 11'h040};
    vecs[7]  = '{1'b0, 32'h0,          1'b1, 1'b1, 32'h0040_0100, 1'b0, 11'h041};
    vecs[8]  = '{1'b1, 32'h0040_0002,  1'b1, 1'b0, 32'h0,         1'b1, 11'h000};
    vecs[9]  = '{1'b0, 32'h0,          1'b1, 1'b0, 32'h0,         1'b1, 11'h000};
    vecs[10] = '{1'b1, 32'h003F_FFFC,  1'b1, 1'b0, 32'h0,         1'b1, 11'h7FF};
    vecs[11] = '{1'b1, 32'h0040_1FF8,  1'b1, 1'b0, 32'h0,         1'b0, 11'h7FE};
    vecs[12] = '{1'b0, 32'h0,          1'b1, 1'b1, 32'h0040_1FF8, 1'b0, 11'h7FF};
    vecs[13] = '{1'b0, 32'h0,          1'b1, 1'b1, 32'h0040_1FFC, 1'b1, 11'h000};
    vecs[14] = '{1'b0, 32'h0,          1'b1, 1'b0, 32'h0,         1'b1, 11'h000};
    vecs[15] = '{1'b0, 32'h0,          1'b1, 1'b0, 32'h0,         1'b1, 11'h000};
    vecs[16] = '{1'b1, 32'h0040_0000,  1'b1, 1'b0, 32'h0,         1'b0, 11'h000};
    vecs[17] = '{1'b0, 32'h0,          1'b1, 1'b1, 32'h0040_0000, 1'b0, 11'h001};

    rst_n = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0);
    #1;
    rst_n = 1'b0;
    #2;
    checkState("reset", 1'b0, 32'd0, 1'b0, 11'h000);

    // Table: streaming, stall, redirects, misaligned/out-of-window targets, last-word fault.
    doReset(1'b1);
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].redir, vecs[i].redirPc, vecs[i].ready);
      tick();
      checkState($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expPc,
                 vecs[i].expFault, vecs[i].expAddr);
    end

    // Stall from reset: queue fills, address holds at 2, head stays on RESET_PC.
    doReset(1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkState($sformatf("stall%0d", i), 1'b1, 32'h0040_0000, 1'b0, (i == 0) ? 11'h001 : 11'h002);
    end
    applyStimulus(1'b0, 32'd0, 1'b1);
    tick();
    checkState("drain0", 1'b1, 32'h0040_0004, 1'b0, 11'h003);
    tick();
    checkState("drain1", 1'b1, 32'h0040_0008, 1'b0, 11'h004);

    // Redirect with a full queue while decode is accepting: one bubble, then the target.
    applyStimulus(1'b1, 32'h0040_0100, 1'b1);
    tick();
    checkState("redirBubble", 1'b0, 32'd0, 1'b0, 11'h040);
    applyStimulus(1'b0, 32'd0, 1'b1);
    tick();
    checkState("redirTarget", 1'b1, 32'h0040_0100, 1'b0, 11'h041);
    tick();
    checkState("redirNext", 1'b1, 32'h0040_0104, 1'b0, 11'h042);

    // Short asynchronous reset pulse between edges.
    #1;
    rst_n = 1'b0;
    #1;
    checkState("pulseLow", 1'b0, 32'd0, 1'b0, 11'h000);
    #1;
    rst_n = 1'b1;
    tick();
    checkState("pulseRestart0", 1'b1, 32'h0040_0000, 1'b0, 11'h001);
    tick();
    checkState("pulseRestart1", 1'b1, 32'h0040_0004, 1'b0, 11'h002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
